// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings accepted on the op port (MDU_MULT .. MDU_MTLO)
//   - FSM state type for mul_div_unit
//   - hlWrite encodings (bit 1 = HI, bit 0 = LO)
// No ports; imported by mul_div_unit and mdu_divider.

package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam logic [1:0] HL_NONE = 2'b00;
    localparam logic [1:0] HL_LO   = 2'b01;
    localparam logic [1:0] HL_HI   = 2'b10;
    localparam logic [1:0] HL_BOTH = 2'b11;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned iterative restoring divider, one quotient bit per cycle.
// The first quotient bit is produced at the start edge straight from the
// inputs, so quotient/remainder are valid (with o_done high) in the WIDTH-th
// cycle after start. Results hold until the next start.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_start         load operands and begin (ignored while running)
//   i_flush         abandon the running division
//   i_dividend      unsigned dividend
//   i_divisor       unsigned divisor (0 yields all-ones quotient, remainder = dividend)
//   o_done          one-cycle pulse, results valid
//   o_quotient      quotient
//   o_remainder     remainder

module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;

    logic [WIDTH-1:0] w_cur_rem;
    logic [WIDTH-1:0] w_cur_quot;
    logic [WIDTH-1:0] w_cur_div;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_next_rem;
    logic [WIDTH-1:0] w_next_quot;

    // While idle the step operates on the incoming operands (first bit at start).
    assign w_cur_rem   = r_busy ? r_rem     : '0;
    assign w_cur_quot  = r_busy ? r_quot    : i_dividend;
    assign w_cur_div   = r_busy ? r_divisor : i_divisor;

    assign w_shift     = {w_cur_rem, w_cur_quot[WIDTH-1]};
    assign w_fits      = (w_shift >= {1'b0, w_cur_div});
    assign w_next_rem  = w_fits ? (w_shift[WIDTH-1:0] - w_cur_div) : w_shift[WIDTH-1:0];
    assign w_next_quot = {w_cur_quot[WIDTH-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_rem  <= w_next_rem;
                r_quot <= w_next_quot;
                r_cnt  <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (i_start) begin
                r_rem     <= w_next_rem;
                r_quot    <= w_next_quot;
                r_divisor <= i_divisor;
                r_cnt     <= CW'(WIDTH - 1);
                r_busy    <= 1'b1;
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit, sole writer of HI/LO.
// Handles MULT, MULTU, DIV, DIVU (multi-cycle, busy high) and MTHI/MTLO
// (single cycle). Sign handling, the shift-add multiplier and all output
// registers live here; division magnitudes go to mdu_divider.
// Build option: MDU_FAST_MULT_EN -- when defined, MULT/MULTU use one registered
// '*' stage (result two cycles after accept) instead of WIDTH shift-add steps.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start, op       request and opcode (0..5 valid, 6/7 ignored)
//   srcA, srcB      rs / rt operands
//   flush           abort the in-flight operation, no HI/LO write
//   busy            multi-cycle operation in progress
//   hiOut, loOut    HI/LO write data (held outside write cycles)
//   hlWrite         one-cycle write enables {HI, LO}
//
// state   | meaning
// IDLE    | accepting requests; MTHI/MTLO complete here
// MUL     | multiplying (shift-add steps or single fast stage)
// DIV     | waiting for mdu_divider
// DONE    | hlWrite = 11 for this one cycle

module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut,
    output logic [1:0]       hlWrite
);

    mdu_state_t       r_state;
    logic             r_busy;
    logic [1:0]       r_hl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_mag_a;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_b_zero;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_accept;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_mul_res;

    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_a_neg  = w_signed & srcA[WIDTH-1];
    assign w_b_neg  = w_signed & srcB[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -srcA : srcA;
    assign w_mag_b  = w_b_neg ? -srcB : srcB;
    assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
    assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign w_accept = start && !flush && (op <= MDU_MTLO) && (r_state == ST_IDLE);

`ifdef MDU_FAST_MULT_EN
    logic [WIDTH-1:0] r_mag_b;

    assign w_prod_mag = {{WIDTH{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, r_mag_b};
`else
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_mul_sum;

    // r_prod = {partial product, unused multiplier bits}; add into the upper
    // half when the current multiplier bit is set, then shift right.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mag_a} : '0);
    assign w_prod_mag = {w_mul_sum, r_prod[WIDTH-1:1]};
`endif

    assign w_mul_res = r_neg_q ? -w_prod_mag : w_prod_mag;

    // MIN / -1 needs no special case: |MIN| / 1 negated wraps back to MIN.
    assign w_quot = r_neg_q ? -w_div_q : w_div_q;
    assign w_rem  = r_neg_r ? -w_div_r : w_div_r;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept && w_is_div),
        .i_flush     (flush),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_hl     <= HL_NONE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a_raw  <= '0;
            r_mag_a  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
`ifdef MDU_FAST_MULT_EN
            r_mag_b  <= '0;
`else
            r_prod   <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_hl <= HL_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            MDU_MTHI: begin
                                r_hi <= srcA;
                                r_hl <= HL_HI;
                            end
                            MDU_MTLO: begin
                                r_lo <= srcA;
                                r_hl <= HL_LO;
                            end
                            default: begin
                                r_busy   <= 1'b1;
                                r_a_raw  <= srcA;
                                r_mag_a  <= w_mag_a;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_b_zero <= (srcB == '0);
                                if (w_is_mul) begin
                                    r_state <= ST_MUL;
`ifdef MDU_FAST_MULT_EN
                                    r_mag_b <= w_mag_b;
`else
                                    r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
                                    r_cnt   <= CW'(WIDTH);
`endif
                                end else begin
                                    r_state <= ST_DIV;
                                end
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
`ifdef MDU_FAST_MULT_EN
                        r_hi    <= w_mul_res[2*WIDTH-1:WIDTH];
                        r_lo    <= w_mul_res[WIDTH-1:0];
                        r_hl    <= HL_BOTH;
                        r_state <= ST_DONE;
`else
                        r_prod <= w_prod_mag;
                        r_cnt  <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_hi    <= w_mul_res[2*WIDTH-1:WIDTH];
                            r_lo    <= w_mul_res[WIDTH-1:0];
                            r_hl    <= HL_BOTH;
                            r_state <= ST_DONE;
                        end
`endif
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_div_done) begin
                        r_lo    <= r_b_zero ? '1 : w_quot;
                        r_hi    <= r_b_zero ? r_a_raw : w_rem;
                        r_hl    <= HL_BOTH;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign hiOut   = r_hi;
    assign loOut   = r_lo;
    assign hlWrite = r_hl;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (WIDTH = 32).
// The driver predicts each HI/LO write (cycle, enables, data) from plain
// 64-bit arithmetic and queues it; a negedge monitor pops and compares on
// every hlWrite pulse. Busy is checked cycle by cycle from the driver.

module tb_mul_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
    localparam int L_MUL = 2;
`else
    localparam int L_MUL = W + 1;
`endif
    localparam int L_DIV = W + 1;

    logic         clk    = 1'b0;
    logic         rst    = 1'b0;
    logic         start  = 1'b0;
    logic [2:0]   op     = 3'd0;
    logic [W-1:0] srcA   = '0;
    logic [W-1:0] srcB   = '0;
    logic         flush  = 1'b0;
    logic         busy;
    logic [W-1:0] hiOut;
    logic [W-1:0] loOut;
    logic [1:0]   hlWrite;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .busy    (busy),
        .hiOut   (hiOut),
        .loOut   (loOut),
        .hlWrite (hlWrite)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [1:0]   hl;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && hlWrite !== 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected hlWrite", 64'(hlWrite), 64'd0);
            end else begin
                e = sb.pop_front();
                check("write cycle", 64'(cyc), 64'(e.cyc));
                check("hlWrite", 64'(hlWrite), 64'(e.hl));
                check("hiOut", 64'(hiOut), 64'(e.hi));
                check("loOut", 64'(loOut), 64'(e.lo));
            end
        end
    end

    // Reference: what HI/LO should hold after the operation, from the ISA rules.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [1:0] hl, output logic [W-1:0] hi, output logic [W-1:0] lo);
        int          ia, ib;
        longint      sa, sb_l, q, r;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb_l = ib;
        hl = 2'b11;
        hi = m_hi;
        lo = m_lo;
        case (o)
            3'd0: begin
                p  = sa * sb_l;
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    q  = sa / sb_l;
                    r  = sa % sb_l;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd4: begin
                hl = 2'b10;
                hi = a;
            end
            default: begin
                hl = 2'b01;
                lo = a;
            end
        endcase
        m_hi = hi;
        m_lo = lo;
    endtask

    function automatic int busy_len(input logic [2:0] o);
        if (o <= 3'd1) return L_MUL;
        if (o <= 3'd3) return L_DIV;
        return 0;
    endfunction

    function automatic int write_lat(input logic [2:0] o);
        if (o >= 3'd4) return 1;
        return busy_len(o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start for one cycle; returns one cycle later with start low.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        if (push && o <= 3'd5) begin
            e.cyc = cyc + write_lat(o);
            model(o, a, b, e.hl, e.hi, e.lo);
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        srcA  = $urandom();
        srcB  = $urandom();
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        issue(o, a, b, 1'b1);
        n = busy_len(o);
        for (int k = 1; k <= n; k++) begin
            check("busy high", 64'(busy), 64'd1);
            tick();
        end
        check("busy low after op", 64'(busy), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = 32'd1;
            4:       v = W'($urandom_range(0, 15));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin : driver
        int c0;
        logic [2:0] o;

        repeat (3) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset hlWrite", 64'(hlWrite), 64'd0);
        check("reset hiOut", 64'(hiOut), 64'd0);
        check("reset loOut", 64'(loOut), 64'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFF_FFFE, 32'h3);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2);
        run_op(3'd3, 32'h7, 32'h2);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h5, 32'h0);
        run_op(3'd2, 32'hFFFF_FFF7, 32'h0);
        run_op(3'd2, 32'h7, 32'hFFFF_FFFE);
        run_op(3'd0, 32'h3, 32'h4);

        // back-to-back MT ops, busy low throughout
        issue(3'd4, 32'h1234_5678, 32'h0, 1'b1);
        check("busy MTHI", 64'(busy), 64'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b1);
        check("busy MTLO", 64'(busy), 64'd0);
        tick();
        check("busy after MT", 64'(busy), 64'd0);

        // invalid op codes do nothing
        issue(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
        check("busy op6", 64'(busy), 64'd0);
        issue(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);
        check("busy op7", 64'(busy), 64'd0);
        repeat (2) tick();

        // flush mid-divide, then a new MULTU right away
        c0 = cyc;
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        repeat (9) tick();
        check("busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush cycle", 64'(cyc - c0), 64'd11);
        check("busy after flush", 64'(busy), 64'd0);
        run_op(3'd1, 32'd6, 32'd7);

        // start while busy is ignored
        issue(3'd0, 32'd5, 32'hFFFF_FFFD, 1'b1);
        start = 1'b1;
        op    = 3'd0;
        srcA  = 32'd7;
        srcB  = 32'd9;
        tick();
        start = 1'b0;
        repeat (L_MUL + 2) tick();
        check("busy after ignored start", 64'(busy), 64'd0);

        // reset in the middle of a divide
        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        repeat (7) tick();
        rst = 1'b0;
        tick();
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset hlWrite", 64'(hlWrite), 64'd0);
        check("mid reset hiOut", 64'(hiOut), 64'd0);
        check("mid reset loOut", 64'(loOut), 64'd0);
        m_hi = '0;
        m_lo = '0;
        rst  = 1'b1;
        repeat (W + 4) tick();

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            run_op(o, pick(), pick());
        end

        repeat (5) tick();
        check("pending writes", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS core. It sits directly upstream of the HI/LO register pair and is the only writer of HI/LO. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage and drives the HI/LO data and the 2-bit write-enable. Multi-cycle operations assert `busy` so the pipeline can stall any HI/LO consumer.

## Interface
- `WIDTH`, default 32: operand width; the result is 2×WIDTH, split into HI and LO.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-low (0 = reset).
- `start`  in  1  operation request, sampled at the rising edge.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are ignored.
- `srcA`  in  WIDTH  rs operand: multiplicand, dividend, or MT data.
- `srcB`  in  WIDTH  rt operand: multiplier or divisor.
- `flush`  in  1  abort the in-flight operation (exception or branch squash).
- `busy`  out  1  an operation is in progress; `start` is ignored while high.
- `hiOut`  out  WIDTH  HI write data.
- `loOut`  out  WIDTH  LO write data.
- `hlWrite`  out  2  bit 1 writes HI, bit 0 writes LO; one-cycle pulse.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. All outputs are registered.
- **Reset** (`rst`=0 at an edge): state goes to IDLE. `busy`=0, `hlWrite`=2'b00, `hiOut`=`loOut`=0. An in-flight operation is discarded with no write.
- **Accept:** in IDLE, with `start`=1, `flush`=0 and a valid `op`. Operands are latched at that edge. `start` is ignored when `busy`=1 or `flush`=1.
- **MTHI / MTLO:**
  - Single cycle; `busy` stays 0.
  - Next cycle: `hlWrite`=2'b10 with `hiOut`=`srcA` (MTHI), or `hlWrite`=2'b01 with `loOut`=`srcA` (MTLO).
- **MULT / MULTU:**
  - Shift-add over WIDTH iterations.
  - Signed operands are converted to magnitudes; the 2×WIDTH product is negated if the operand signs differ.
  - Result: `hiOut`=product[2W-1:W], `loOut`=product[W-1:0].
- **DIV / DIVU:**
  - Restoring division over WIDTH iterations on magnitudes.
  - Quotient is negative if the operand signs differ. Remainder takes the sign of the dividend.
  - Result: `loOut`=quotient, `hiOut`=remainder.
- **Divide by zero:** same latency; `loOut`=all ones, `hiOut`=dividend.
- **Signed overflow** (MIN/−1): `loOut`=MIN, `hiOut`=0. This falls out of the algorithm naturally.
- **DONE:** `hlWrite`=2'b11 for exactly one cycle, then return to IDLE.
- **Flush:** `flush`=1 in any non-IDLE state moves to IDLE at that edge. `busy` drops the next cycle and `hlWrite` is never asserted for the aborted operation. A flush in IDLE has no effect.
- `hiOut`/`loOut` hold their last value outside write cycles.

## Timing
- Start is accepted in cycle 0.
- MUL/DIV: `busy`=1 in cycles 1..WIDTH+1. `hlWrite`=2'b11 in cycle WIDTH+1 (33 for the default). HI/LO captures at the end of that cycle.
- `busy`=0 in cycle WIDTH+2, so a new `start` can be accepted in cycle WIDTH+2.
- MT ops: `hlWrite` is asserted in cycle 1. Back-to-back MT ops are allowed every cycle.
- There is no combinational path from any input to any output.

## Configuration
- `MDU_FAST_MULT_EN`, defined:
  - MULT/MULTU use a single-stage registered `*` product.
  - `busy`=1 in cycles 1..2; `hlWrite`=2'b11 in cycle 2.
  - Division is unchanged.
- `MDU_FAST_MULT_EN`, undefined: multiplication uses the iterative WIDTH+1 latency above. Results are bit-identical either way.

## Structure
- Package `mdu_pkg`:
  - `op` encoding localparams (`MDU_MULT`..`MDU_MTLO`).
  - FSM state typedef.
  - `hlWrite` constants (`HL_HI`, `HL_LO`, `HL_BOTH`).
- Sub-module `mdu_divider`: unsigned iterative restoring divider with start, flush and done. The top level owns sign handling, the multiplier and the output registers.

## Test plan
- MULT −2 × 3 (0xFFFFFFFE, 0x3) → cycle 33: `hlWrite`=11, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. Both at cycle 33, with `busy` high in cycles 1–33.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- DIV started, `flush` at cycle 10 → `busy`=0 at cycle 11, no `hlWrite` pulse. A new MULTU 6×7 is accepted at cycle 11 and gives lo=42 at cycle 44.
- `start` MULT while busy → ignored, only the first result is written. `rst`=0 mid-DIV → all outputs 0, no write.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → `hlWrite`=10 in cycle 1 and 01 in cycle 2, with matching data and `busy` low throughout. With `MDU_FAST_MULT_EN`, MULT 3×4 → lo=12 in cycle 2.
